// File: rtl/bsk_srv_bdc_tx.sv
// ---------------------------------------------------------------------------
// bsk_srv_bdc_tx
//
// Bootstrapping-key server broadcast transmitter. On start, one batch of
// UNIT_NB units is pushed from a source stream onto a shared broadcast bus.
// A unit moves only in cycles where this server owns the broadcast slot.
// Whenever no unit is being sent, the bus is driven to all-zeros, so several
// servers with disjoint slots can be OR-merged downstream.
//
// Parameters
//   SRV_ID   server index (identification only)
//   OP_W     coefficient width
//   UNIT_NB  units per batch (1 .. 2**BSK_UNIT_W)
//
// Ports
//   clk, s_rst            clock, synchronous active-high reset
//   start                 request one batch (accepted only when idle)
//   start_br_loop         br_loop tag latched at start
//   start_group           group tag latched at start
//   busy                  batch in progress (registered)
//   done                  one-cycle completion pulse (registered)
//   slot_en               broadcast slot granted this cycle
//   src_data/vld/rdy      source stream of unit coefficients
//   bsk_srv_bdc_*         broadcast bus (coefficients, avail, unit, tags),
//                         registered, zero when nothing is sent
// ---------------------------------------------------------------------------
package bsk_ntw_common_param_pkg;
    parameter int BSK_DIST_COEF_NB = 4;
    parameter int BSK_UNIT_W       = 3;
    parameter int BSK_GROUP_W      = 2;
endpackage

package param_tfhe_pkg;
    parameter int LWE_K_W = 10;
endpackage

module bsk_srv_bdc_tx
    import bsk_ntw_common_param_pkg::*;
    import param_tfhe_pkg::*;
#(
    parameter int SRV_ID  = 0,
    parameter int OP_W    = 32,
    parameter int UNIT_NB = 8
) (
    input  logic                             clk,
    input  logic                             s_rst,
    input  logic                             start,
    input  logic [LWE_K_W-1:0]               start_br_loop,
    input  logic [BSK_GROUP_W-1:0]           start_group,
    output logic                             busy,
    output logic                             done,
    input  logic                             slot_en,
    input  logic [BSK_DIST_COEF_NB*OP_W-1:0] src_data,
    input  logic                             src_vld,
    output logic                             src_rdy,
    output logic [BSK_DIST_COEF_NB*OP_W-1:0] bsk_srv_bdc_bsk,
    output logic [BSK_DIST_COEF_NB-1:0]      bsk_srv_bdc_avail,
    output logic [BSK_UNIT_W-1:0]            bsk_srv_bdc_unit,
    output logic [BSK_GROUP_W-1:0]           bsk_srv_bdc_group,
    output logic [LWE_K_W-1:0]               bsk_srv_bdc_br_loop
);

    if (UNIT_NB < 1 || UNIT_NB > 2**BSK_UNIT_W || SRV_ID < 0) begin : g_param_chk
        $error("bsk_srv_bdc_tx: illegal UNIT_NB or SRV_ID");
    end

    localparam logic [BSK_UNIT_W-1:0] LAST_UNIT = BSK_UNIT_W'(UNIT_NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [BSK_UNIT_W-1:0]              r_unit_cnt;
    logic [LWE_K_W-1:0]                 r_br_loop;
    logic [BSK_GROUP_W-1:0]             r_group;
    logic                               r_busy;
    logic                               r_done;

    logic [BSK_DIST_COEF_NB*OP_W-1:0]   r_bsk_p1;
    logic [BSK_DIST_COEF_NB-1:0]        r_avail_p1;
    logic [BSK_UNIT_W-1:0]              r_unit_p1;
    logic [BSK_GROUP_W-1:0]             r_group_p1;
    logic [LWE_K_W-1:0]                 r_br_loop_p1;

    logic                               w_src_rdy;
    logic                               w_xfer;
    logic                               w_last;

    // Ready is also masked by reset so nothing can be consumed while the
    // block is being cleared.
    assign w_src_rdy = (r_state == ST_SEND) & slot_en & ~s_rst;
    assign w_xfer    = src_vld & w_src_rdy;
    assign w_last    = (r_unit_cnt == LAST_UNIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_SEND;
            ST_SEND: if (w_xfer && w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // busy/done are derived from the next state so they line up with the
    // state they describe while still being plain flops.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_unit_cnt <= '0;
            r_br_loop  <= '0;
            r_group    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (r_state == ST_IDLE && start) begin
                r_unit_cnt <= '0;
                r_br_loop  <= start_br_loop;
                r_group    <= start_group;
            end else if (w_xfer && !w_last) begin
                r_unit_cnt <= r_unit_cnt + 1'b1;
            end
        end
    end

    // ---- stage p1: broadcast bus register ----
    // Zero in every cycle without a transfer so the downstream OR merge of
    // several servers never sees stale data.
    always_ff @(posedge clk) begin
        if (s_rst || !w_xfer) begin
            r_bsk_p1     <= '0;
            r_avail_p1   <= '0;
            r_unit_p1    <= '0;
            r_group_p1   <= '0;
            r_br_loop_p1 <= '0;
        end else begin
            r_bsk_p1     <= src_data;
            r_avail_p1   <= '1;
            r_unit_p1    <= r_unit_cnt;
            r_group_p1   <= r_group;
            r_br_loop_p1 <= r_br_loop;
        end
    end

    assign src_rdy             = w_src_rdy;
    assign busy                = r_busy;
    assign done                = r_done;
    assign bsk_srv_bdc_bsk     = r_bsk_p1;
    assign bsk_srv_bdc_avail   = r_avail_p1;
    assign bsk_srv_bdc_unit    = r_unit_p1;
    assign bsk_srv_bdc_group   = r_group_p1;
    assign bsk_srv_bdc_br_loop = r_br_loop_p1;

endmodule

// File: tb/tb_bsk_srv_bdc_tx.sv
// ---------------------------------------------------------------------------
// tb_bsk_srv_bdc_tx
//
// Three transmitters: instances 0 and 1 (UNIT_NB=4) share the bus through an
// OR merge with disjoint slots; instance 2 has UNIT_NB=1. A behavioural model
// of each server predicts every output each cycle; batch logs are also
// compared against hand-written unit/tag sequences.
// ---------------------------------------------------------------------------
module tb_bsk_srv_bdc_tx;
    import bsk_ntw_common_param_pkg::*;
    import param_tfhe_pkg::*;

    localparam int OP_W  = 8;
    localparam int BUS_W = BSK_DIST_COEF_NB * OP_W;
    localparam int NI    = 3;

    logic clk;
    logic s_rst;

    logic                   start         [NI];
    logic [LWE_K_W-1:0]     start_br_loop [NI];
    logic [BSK_GROUP_W-1:0] start_group   [NI];
    logic                   busy          [NI];
    logic                   done          [NI];
    logic                   slot_en       [NI];
    logic [BUS_W-1:0]       src_data      [NI];
    logic                   src_vld       [NI];
    logic                   src_rdy       [NI];
    logic [BUS_W-1:0]            bsk      [NI];
    logic [BSK_DIST_COEF_NB-1:0] avail    [NI];
    logic [BSK_UNIT_W-1:0]       unit     [NI];
    logic [BSK_GROUP_W-1:0]      grp      [NI];
    logic [LWE_K_W-1:0]          brl      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bsk_srv_bdc_tx #(
            .SRV_ID  (g),
            .OP_W    (OP_W),
            .UNIT_NB ((g == 2) ? 1 : 4)
        ) u_dut (
            .clk                 (clk),
            .s_rst               (s_rst),
            .start               (start[g]),
            .start_br_loop       (start_br_loop[g]),
            .start_group         (start_group[g]),
            .busy                (busy[g]),
            .done                (done[g]),
            .slot_en             (slot_en[g]),
            .src_data            (src_data[g]),
            .src_vld             (src_vld[g]),
            .src_rdy             (src_rdy[g]),
            .bsk_srv_bdc_bsk     (bsk[g]),
            .bsk_srv_bdc_avail   (avail[g]),
            .bsk_srv_bdc_unit    (unit[g]),
            .bsk_srv_bdc_group   (grp[g]),
            .bsk_srv_bdc_br_loop (brl[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int unsigned NB [NI] = '{4, 4, 1};
    int          m_phase [NI];   // 0 waiting for start, 1 sending, 2 finishing
    int          m_sent  [NI];   // units already broadcast in this batch
    int          m_seq   [NI];   // source items consumed so far
    int          m_br    [NI];
    int          m_grp   [NI];
    logic [BUS_W-1:0] e_bsk [NI];
    int          e_avail [NI];
    int          e_unit  [NI];
    int          e_grp   [NI];
    int          e_br    [NI];
    int          e_busy  [NI];
    int          e_done  [NI];

    typedef struct {
        int inst;
        int unit;
        int br;
        int grp;
    } log_t;
    log_t q_log [$];
    int   q_mrg [$];
    int   n_done [NI];

    int n_chk;
    int n_err;

    function automatic logic [BUS_W-1:0] pat(input int i, input int s);
        logic [31:0] v;
        v = 32'((i + 1) * 32'h0100_0000 + s * 32'h0001_0203 + 32'h00A0_00B0);
        return BUS_W'(v);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic xf;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("src_rdy", i, 64'(src_rdy[i]), 64'((m_phase[i] == 1) && slot_en[i] && !s_rst));
            xf = (m_phase[i] == 1) && slot_en[i] && src_vld[i] && !s_rst;
            e_bsk[i] = '0; e_avail[i] = 0; e_unit[i] = 0; e_grp[i] = 0; e_br[i] = 0;
            if (s_rst) begin
                m_phase[i] = 0; m_sent[i] = 0; m_br[i] = 0; m_grp[i] = 0;
            end else if (m_phase[i] == 0) begin
                if (start[i]) begin
                    m_phase[i] = 1; m_sent[i] = 0;
                    m_br[i] = int'(start_br_loop[i]); m_grp[i] = int'(start_group[i]);
                end
            end else if (m_phase[i] == 1) begin
                if (xf) begin
                    e_bsk[i] = src_data[i];
                    e_avail[i] = (1 << BSK_DIST_COEF_NB) - 1;
                    e_unit[i] = m_sent[i]; e_grp[i] = m_grp[i]; e_br[i] = m_br[i];
                    m_sent[i]++;
                    m_seq[i]++;
                    if (m_sent[i] == int'(NB[i])) m_phase[i] = 2;
                end
            end else begin
                m_phase[i] = 0;
            end
            e_busy[i] = (m_phase[i] != 0) ? 1 : 0;
            e_done[i] = (m_phase[i] == 2) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("bsk", i, 64'(bsk[i]), 64'(e_bsk[i]));
            chk("avail", i, 64'(avail[i]), 64'(e_avail[i]));
            chk("unit", i, 64'(unit[i]), 64'(e_unit[i]));
            chk("group", i, 64'(grp[i]), 64'(e_grp[i]));
            chk("br_loop", i, 64'(brl[i]), 64'(e_br[i]));
            chk("busy", i, 64'(busy[i]), 64'(e_busy[i]));
            chk("done", i, 64'(done[i]), 64'(e_done[i]));
            if (avail[i] != '0) q_log.push_back('{i, int'(unit[i]), int'(brl[i]), int'(grp[i])});
            if (done[i] === 1'b1) n_done[i]++;
            src_data[i] = pat(i, m_seq[i]);
        end
        chk("mrg_bsk", 9, 64'(bsk[0] | bsk[1]), 64'(e_bsk[0] | e_bsk[1]));
        chk("mrg_meta", 9, 64'({avail[0] | avail[1], unit[0] | unit[1], grp[0] | grp[1], brl[0] | brl[1]}),
            64'({4'(e_avail[0] | e_avail[1]), 3'(e_unit[0] | e_unit[1]), 2'(e_grp[0] | e_grp[1]),
                 10'(e_br[0] | e_br[1])}));
        if ((avail[0] | avail[1]) != '0) q_mrg.push_back(int'(brl[0] | brl[1]) * 16 + int'(unit[0] | unit[1]));
    endtask

    task automatic idle_in();
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; slot_en[i] = 1'b0; src_vld[i] = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic go(input int i, input int br, input int g);
        start[i] = 1'b1; start_br_loop[i] = LWE_K_W'(br); start_group[i] = BSK_GROUP_W'(g);
        tick();
        start[i] = 1'b0;
    endtask

    // Literal expectations: units 0..n-1 in order, fixed tags, given done count.
    task automatic check_log(input int inst, input int n, input int br, input int g, input int exp_done);
        int k;
        k = 0;
        foreach (q_log[j]) begin
            if (q_log[j].inst == inst) begin
                chk("log_unit", inst, 64'(q_log[j].unit), 64'(k));
                chk("log_br", inst, 64'(q_log[j].br), 64'(br));
                chk("log_grp", inst, 64'(q_log[j].grp), 64'(g));
                k++;
            end
        end
        chk("log_len", inst, 64'(k), 64'(n));
        chk("done_cnt", inst, 64'(n_done[inst]), 64'(exp_done));
        q_log.delete();
        q_mrg.delete();
        for (int i = 0; i < NI; i++) n_done[i] = 0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < NI; i++) begin
            m_phase[i] = 0; m_sent[i] = 0; m_seq[i] = 0; m_br[i] = 0; m_grp[i] = 0; n_done[i] = 0;
            start_br_loop[i] = '0; start_group[i] = '0; src_data[i] = pat(i, 0);
        end
        idle_in();

        // Reset state
        s_rst = 1'b1;
        ticks(2);
        chk("rst_busy", 0, 64'(busy[0]), 64'd0);
        chk("rst_avail", 0, 64'(avail[0]), 64'd0);
        s_rst = 1'b0;
        ticks(2);

        // Basic batch: continuous slot and source
        go(0, 5, 2);
        slot_en[0] = 1'b1; src_vld[0] = 1'b1;
        ticks(6);
        idle_in();
        ticks(2);
        check_log(0, 4, 5, 2, 1);

        // Slot gating: alternate slot grant
        go(0, 6, 1);
        src_vld[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            slot_en[0] = (k % 2 == 0);
            tick();
        end
        idle_in();
        ticks(2);
        check_log(0, 4, 6, 1, 1);

        // Source stall of three cycles mid-batch
        go(0, 4, 3);
        slot_en[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            src_vld[0] = !(k >= 2 && k <= 4);
            tick();
        end
        idle_in();
        ticks(2);
        check_log(0, 4, 4, 3, 1);

        // Start held high during the batch and the completion cycle
        go(0, 5, 0);
        slot_en[0] = 1'b1; src_vld[0] = 1'b1;
        start[0] = 1'b1; start_br_loop[0] = 10'd7; start_group[0] = 2'd3;
        ticks(5);
        idle_in();
        ticks(3);
        check_log(0, 4, 5, 0, 1);

        // Reset mid-batch, then a fresh batch
        go(0, 5, 2);
        slot_en[0] = 1'b1; src_vld[0] = 1'b1;
        ticks(2);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        idle_in();
        ticks(2);
        chk("abort_busy", 0, 64'(busy[0]), 64'd0);
        check_log(0, 2, 5, 2, 0);
        go(0, 3, 1);
        slot_en[0] = 1'b1; src_vld[0] = 1'b1;
        ticks(6);
        idle_in();
        ticks(2);
        check_log(0, 4, 3, 1, 1);

        // Two servers OR-merged with disjoint slots
        start[0] = 1'b1; start_br_loop[0] = 10'd1; start_group[0] = 2'd1;
        start[1] = 1'b1; start_br_loop[1] = 10'd2; start_group[1] = 2'd2;
        tick();
        start[0] = 1'b0; start[1] = 1'b0;
        src_vld[0] = 1'b1; src_vld[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            slot_en[0] = (k % 2 == 0);
            slot_en[1] = (k % 2 == 1);
            tick();
        end
        idle_in();
        ticks(2);
        chk("mrg_len", 9, 64'(q_mrg.size()), 64'd8);
        for (int j = 0; j < 8 && j < q_mrg.size(); j++)
            chk("mrg_seq", j, 64'(q_mrg[j]), 64'(((j % 2 == 0) ? 1 : 2) * 16 + j / 2));
        check_log(1, 4, 2, 2, 1);

        // Single-unit batch
        go(2, 9, 1);
        slot_en[2] = 1'b1; src_vld[2] = 1'b1;
        ticks(3);
        idle_in();
        ticks(2);
        check_log(2, 1, 9, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bsk_srv_bdc_tx.md
BSK_SRV_BDC_TX -- requirements
Module: bsk_srv_bdc_tx

Interface
REQ-001 Parameter SRV_ID, default 0; server index, for identification only, with no functional effect.
REQ-002 Parameter OP_W, default 32; coefficient width.
REQ-003 Parameter UNIT_NB, default 8; units per batch, range 1..2**BSK_UNIT_W.
REQ-004 The block SHALL use BSK_DIST_COEF_NB, BSK_UNIT_W, BSK_GROUP_W and LWE_K_W from the bsk_ntw_common_param_pkg and param_tfhe_pkg packages.
REQ-005 The block SHALL have one clock, clk; reset is synchronous and active-high, s_rst.
REQ-006 Ports SHALL be exactly as follows (name  direction  width  meaning):
- clk  in  1  clock.
- s_rst  in  1  synchronous active-high reset.
- start  in  1  request to broadcast one batch.
- start_br_loop  in  LWE_K_W  br_loop tag for the batch.
- start_group  in  BSK_GROUP_W  group tag for the batch.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse when a batch completes.
- slot_en  in  1  broadcast slot granted to this server this cycle.
- src_data  in  BSK_DIST_COEF_NB*OP_W  coefficients for the next unit.
- src_vld  in  1  src_data is valid.
- src_rdy  out  1  src_data is accepted when src_vld and src_rdy are both high.
- bsk_srv_bdc_bsk  out  BSK_DIST_COEF_NB*OP_W  broadcast coefficients.
- bsk_srv_bdc_avail  out  BSK_DIST_COEF_NB  per-coefficient valid flag.
- bsk_srv_bdc_unit  out  BSK_UNIT_W  unit index.
- bsk_srv_bdc_group  out  BSK_GROUP_W  group tag.
- bsk_srv_bdc_br_loop  out  LWE_K_W  br_loop tag.

Function
REQ-007 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-008 In IDLE with start=1, the block SHALL latch start_br_loop and start_group, clear unit_cnt to 0, and enter SEND on the next cycle; busy=1 from that cycle.
REQ-009 When the FSM is not in IDLE, start SHALL be ignored, and the latched tags SHALL not change.
REQ-010 src_rdy SHALL equal (state==SEND) & slot_en, combinationally.
REQ-011 A transfer SHALL be src_vld & src_rdy.
- On the clock edge of a transfer, the bus outputs SHALL register: bsk=src_data, avail=all ones, unit=unit_cnt, group=latched group, br_loop=latched br_loop.
- Latency from transfer to bus output: 1 cycle.
REQ-012 In any cycle with no transfer, all five bus outputs SHALL be registered to all-zeros on the next edge; this gives idle-zero for the downstream OR merge.
REQ-013 unit_cnt SHALL increment by 1 on each transfer.
REQ-014 A transfer with unit_cnt==UNIT_NB-1 SHALL move the FSM to DONE; unit_cnt SHALL not wrap past UNIT_NB-1 within a batch.
REQ-015 src_vld=1 with slot_en=0 SHALL cause no transfer and no counter change; data SHALL be held by the source.
REQ-016 slot_en=1 with src_vld=0 SHALL leave the bus outputs zero, with no counter change.
REQ-017 In DONE, done=1 for exactly one cycle, busy=1; the FSM SHALL return to IDLE on the next edge.
REQ-018 start asserted while in DONE SHALL be ignored; a new batch is accepted in IDLE only.
REQ-019 When UNIT_NB=1, a single transfer SHALL complete the batch.
REQ-020 busy and done SHALL be registered outputs.

Reset
REQ-021 When s_rst=1 at a clock edge:
- the FSM SHALL enter IDLE and unit_cnt and the latched tags SHALL clear to 0;
- busy, done and all bus outputs SHALL be 0 after that edge;
- src_rdy SHALL be 0 while s_rst=1.
REQ-022 Reset mid-batch SHALL abandon the batch without a done pulse; the bus SHALL show zeros from the cycle after the reset edge.

Verification
REQ-023 Basic batch: UNIT_NB=4, br_loop=5, group=2, slot_en=1, src_vld=1 continuous -> bus unit 0,1,2,3 on 4 consecutive cycles, each 1 cycle after acceptance; avail all ones; group 2; br_loop 5. done pulses 1 cycle after unit 3; outputs 0 afterward.
REQ-024 Slot gating: slot_en toggling 1,0,1,0 with src_vld=1 -> transfers only on slot_en=1 cycles; bus is zero in the cycles following slot_en=0; the unit sequence stays contiguous.
REQ-025 Source stall: src_vld low for 3 cycles mid-batch -> no unit_cnt change, bus zero for 3 cycles, then resumes at the next unit index.
REQ-026 Start while busy: start with br_loop=7 during a br_loop=5 batch -> ignored; all units carry br_loop 5; a single done pulse.
REQ-027 Reset mid-batch: s_rst after unit 1 of 4 -> bus zero, busy=0, no done pulse. A new start with br_loop=3 then broadcasts units 0..3 tagged 3.
REQ-028 OR compatibility: two instances driven with disjoint slot_en, outputs OR-ed together -> the merged stream equals the interleaved per-server streams with no corruption.
